// File: rtl/pe_ws_os_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : pe_ws_os_dbuf
// Description : Systolic-array PE with weight-stationary MAC and
//               output-stationary accumulate modes, double-buffered weights.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_ws_os_dbuf #(
    parameter int DATA_IN_BW     = 8,
    parameter int WEIGHT_BW      = 8,
    parameter int PARTIAL_SUM_BW = 19,
    parameter bit SATURATE       = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [DATA_IN_BW-1:0]     DIN,
    input  logic                      din_valid,
    output logic [DATA_IN_BW-1:0]     DF_COL,
    output logic                      df_valid,
    input  logic [WEIGHT_BW-1:0]      W_IN,
    input  logic                      w_load,
    input  logic                      w_swap,
    output logic [WEIGHT_BW-1:0]      W_OUT,
    output logic                      w_load_out,
    output logic                      w_swap_out,
    input  logic [PARTIAL_SUM_BW-1:0] PSUM_IN,
    input  logic                      psum_in_valid,
    output logic [PARTIAL_SUM_BW-1:0] PSUM_OUT,
    output logic                      psum_out_valid,
    input  logic                      acc_clear,
    input  logic                      acc_drain,
    output logic                      sat_flag,
    output logic                      coll_err
);

    localparam int c_PROD_BW = DATA_IN_BW + WEIGHT_BW;
    localparam int c_SUM_BW  = PARTIAL_SUM_BW + 1;

    logic [DATA_IN_BW-1:0]     r_df_col;
    logic                      r_df_valid;
    logic [WEIGHT_BW-1:0]      r_w_shadow;
    logic [WEIGHT_BW-1:0]      r_w_active;
    logic                      r_w_load_q;
    logic                      r_w_swap_q;
    logic [PARTIAL_SUM_BW-1:0] r_psum;
    logic                      r_psum_valid;
    logic [PARTIAL_SUM_BW-1:0] r_acc;
    logic                      r_mode_q;
    logic                      r_sat;
    logic                      r_coll;

    logic signed [c_PROD_BW-1:0] w_prod;
    logic [c_SUM_BW-1:0]         w_prod_ext;
    logic [c_SUM_BW-1:0]         w_psum_in_ext;
    logic [PARTIAL_SUM_BW-1:0]   w_acc_eff;
    logic [c_SUM_BW-1:0]         w_acc_ext;
    logic [c_SUM_BW-1:0]         w_ws_res;
    logic [c_SUM_BW-1:0]         w_os_res;
    logic [c_SUM_BW-1:0]         w_prod_res;
    logic [PARTIAL_SUM_BW-1:0]   w_acc_nxt;
    logic [PARTIAL_SUM_BW-1:0]   w_psum_nxt;
    logic                        w_pvalid_nxt;
    logic                        w_sat_set;
    logic                        w_coll_set;

    // Returns {clamp_event, result}; the sum carries one guard bit above the psum width.
    function automatic logic [PARTIAL_SUM_BW:0] f_sat(input logic [PARTIAL_SUM_BW:0] s);
        logic w_ovf;
        w_ovf = s[PARTIAL_SUM_BW] ^ s[PARTIAL_SUM_BW-1];
        if (SATURATE && w_ovf)
            return {1'b1, s[PARTIAL_SUM_BW], {(PARTIAL_SUM_BW-1){~s[PARTIAL_SUM_BW]}}};
        return {1'b0, s[PARTIAL_SUM_BW-1:0]};
    endfunction

    assign w_prod        = $signed(DIN) * $signed(r_w_active);
    assign w_prod_ext    = {{(c_SUM_BW-c_PROD_BW){w_prod[c_PROD_BW-1]}}, w_prod};
    assign w_psum_in_ext = {PSUM_IN[PARTIAL_SUM_BW-1], PSUM_IN};
    // A mode change discards the accumulator at the same edge the new mode takes over.
    assign w_acc_eff     = (mode != r_mode_q) ? '0 : r_acc;
    assign w_acc_ext     = {w_acc_eff[PARTIAL_SUM_BW-1], w_acc_eff};
    assign w_ws_res      = f_sat(w_psum_in_ext + w_prod_ext);
    assign w_os_res      = f_sat(w_acc_ext + w_prod_ext);
    assign w_prod_res    = f_sat(w_prod_ext);

    always_comb begin
        w_acc_nxt    = w_acc_eff;
        w_psum_nxt   = PSUM_IN;
        w_pvalid_nxt = psum_in_valid;
        w_sat_set    = 1'b0;
        w_coll_set   = 1'b0;
        if (!mode) begin
            if (din_valid) begin
                w_psum_nxt = w_ws_res[PARTIAL_SUM_BW-1:0];
                w_sat_set  = w_ws_res[PARTIAL_SUM_BW];
            end
        end else begin
            if (acc_clear && din_valid) begin
                w_acc_nxt = w_prod_res[PARTIAL_SUM_BW-1:0];
                w_sat_set = w_prod_res[PARTIAL_SUM_BW];
            end else if (acc_clear) begin
                w_acc_nxt = '0;
            end else if (din_valid) begin
                w_acc_nxt = w_os_res[PARTIAL_SUM_BW-1:0];
                w_sat_set = w_os_res[PARTIAL_SUM_BW];
            end
            // Local drain wins over an upstream value arriving in the same cycle.
            if (acc_drain) begin
                w_psum_nxt   = r_acc;
                w_pvalid_nxt = 1'b1;
                w_coll_set   = psum_in_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_df_col     <= '0;
            r_df_valid   <= 1'b0;
            r_w_shadow   <= '0;
            r_w_active   <= '0;
            r_w_load_q   <= 1'b0;
            r_w_swap_q   <= 1'b0;
            r_psum       <= '0;
            r_psum_valid <= 1'b0;
            r_acc        <= '0;
            r_mode_q     <= 1'b0;
            r_sat        <= 1'b0;
            r_coll       <= 1'b0;
        end else begin
            r_df_col     <= DIN;
            r_df_valid   <= din_valid;
            r_w_load_q   <= w_load;
            r_w_swap_q   <= w_swap;
            if (w_load)
                r_w_shadow <= W_IN;
            if (w_load && w_swap)
                r_w_active <= W_IN;
            else if (w_swap)
                r_w_active <= r_w_shadow;
            r_psum       <= w_psum_nxt;
            r_psum_valid <= w_pvalid_nxt;
            r_acc        <= w_acc_nxt;
            r_mode_q     <= mode;
            r_sat        <= (r_sat  & ~acc_clear) | w_sat_set;
            r_coll       <= (r_coll & ~acc_clear) | w_coll_set;
        end
    end

    assign DF_COL         = r_df_col;
    assign df_valid       = r_df_valid;
    assign W_OUT          = r_w_shadow;
    assign w_load_out     = r_w_load_q;
    assign w_swap_out     = r_w_swap_q;
    assign PSUM_OUT       = r_psum;
    assign psum_out_valid = r_psum_valid;
    assign sat_flag       = r_sat;
    assign coll_err       = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_pe_ws_os_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_ws_os_dbuf
// Description : Self-checking bench: vector table with scoreboard queue plus
//               hand sequences for reset, weight chain and swap timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_ws_os_dbuf;

    typedef struct {
        string              name;
        logic               mode;
        logic signed [7:0]  din;
        logic               dv;
        logic signed [7:0]  w_in;
        logic               wl;
        logic               ws;
        logic signed [18:0] pin;
        logic               pv;
        logic               clr;
        logic               drn;
        logic signed [18:0] e_psum;
        logic               e_pv;
        logic               e_sat;
        logic               e_coll;
        logic               chk_wrap;
        logic signed [18:0] e_wrap;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic signed [7:0]  din;
    logic               din_valid;
    logic signed [7:0]  w_in;
    logic               w_load;
    logic               w_swap;
    logic signed [18:0] psum_in;
    logic               psum_in_valid;
    logic               acc_clear;
    logic               acc_drain;

    logic signed [7:0]  df_col,   wr_df_col,   b_df_col;
    logic               df_valid, wr_df_valid, b_df_valid;
    logic signed [7:0]  w_out,    wr_w_out,    b_w_out;
    logic               w_load_out, wr_w_load_out, b_w_load_out;
    logic               w_swap_out, wr_w_swap_out, b_w_swap_out;
    logic signed [18:0] psum_out, wr_psum_out, b_psum_out;
    logic               psum_out_valid, wr_psum_out_valid, b_psum_out_valid;
    logic               sat_flag, wr_sat_flag, b_sat_flag;
    logic               coll_err, wr_coll_err, b_coll_err;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;

    always #5 clk = ~clk;

    pe_ws_os_dbuf #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19), .SATURATE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .DIN(din), .din_valid(din_valid),
        .DF_COL(df_col), .df_valid(df_valid), .W_IN(w_in), .w_load(w_load), .w_swap(w_swap),
        .W_OUT(w_out), .w_load_out(w_load_out), .w_swap_out(w_swap_out),
        .PSUM_IN(psum_in), .psum_in_valid(psum_in_valid), .PSUM_OUT(psum_out),
        .psum_out_valid(psum_out_valid), .acc_clear(acc_clear), .acc_drain(acc_drain),
        .sat_flag(sat_flag), .coll_err(coll_err));

    pe_ws_os_dbuf #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .mode(mode), .DIN(din), .din_valid(din_valid),
        .DF_COL(wr_df_col), .df_valid(wr_df_valid), .W_IN(w_in), .w_load(w_load), .w_swap(w_swap),
        .W_OUT(wr_w_out), .w_load_out(wr_w_load_out), .w_swap_out(wr_w_swap_out),
        .PSUM_IN(psum_in), .psum_in_valid(psum_in_valid), .PSUM_OUT(wr_psum_out),
        .psum_out_valid(wr_psum_out_valid), .acc_clear(acc_clear), .acc_drain(acc_drain),
        .sat_flag(wr_sat_flag), .coll_err(wr_coll_err));

    // Bottom PE of a two-deep column, fed by the top PE's weight chain.
    pe_ws_os_dbuf #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19), .SATURATE(1'b1)) u_bot (
        .clk(clk), .rst(rst), .mode(1'b0), .DIN(8'd0), .din_valid(1'b0),
        .DF_COL(b_df_col), .df_valid(b_df_valid), .W_IN(w_out), .w_load(w_load_out), .w_swap(w_swap_out),
        .W_OUT(b_w_out), .w_load_out(b_w_load_out), .w_swap_out(b_w_swap_out),
        .PSUM_IN(19'd0), .psum_in_valid(1'b0), .PSUM_OUT(b_psum_out),
        .psum_out_valid(b_psum_out_valid), .acc_clear(1'b0), .acc_drain(1'b0),
        .sat_flag(b_sat_flag), .coll_err(b_coll_err));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mode = 1'b0; din = '0; din_valid = 1'b0; w_in = '0; w_load = 1'b0; w_swap = 1'b0;
        psum_in = '0; psum_in_valid = 1'b0; acc_clear = 1'b0; acc_drain = 1'b0;
    endtask

    task automatic add(input string n, input int md, input int d, input int dv, input int wi,
                       input int wl, input int ws, input int pin, input int pv, input int clr,
                       input int drn, input int ep, input int epv, input int es, input int ec,
                       input int cw, input int ew);
        vec_t v;
        v.name = n; v.mode = md[0]; v.din = d[7:0]; v.dv = dv[0]; v.w_in = wi[7:0];
        v.wl = wl[0]; v.ws = ws[0]; v.pin = pin[18:0]; v.pv = pv[0]; v.clr = clr[0];
        v.drn = drn[0]; v.e_psum = ep[18:0]; v.e_pv = epv[0]; v.e_sat = es[0];
        v.e_coll = ec[0]; v.chk_wrap = cw[0]; v.e_wrap = ew[18:0];
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   name          md din  dv  w_in  wl ws  pin     pv clr drn  e_psum  epv sat coll cw e_wrap
        add("ws_ld3",      0,  0,  0,    3,  1, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("ws_sw3",      0,  0,  0,    0,  0, 1,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("ws_basic",    0, -5,  1,    0,  0, 0,     100, 1, 0, 0,      85, 1, 0, 0, 0, 0);
        add("ws_pass",     0,  7,  0,    0,  0, 0,     -40, 0, 0, 0,     -40, 0, 0, 0, 0, 0);
        add("ws_byp2",     0,  0,  0,    2,  1, 1,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("db_load7",    0,  4,  1,    7,  1, 0,       0, 1, 0, 0,       8, 1, 0, 0, 0, 0);
        add("db_hold",     0,  4,  1,    0,  0, 0,       0, 1, 0, 0,       8, 1, 0, 0, 0, 0);
        add("db_swap_old", 0,  4,  1,    0,  0, 1,       0, 1, 0, 0,       8, 1, 0, 0, 0, 0);
        add("db_new7",     0,  4,  1,    0,  0, 0,       0, 1, 0, 0,      28, 1, 0, 0, 0, 0);
        add("db_byp9_old", 0,  1,  1,    9,  1, 1,       0, 1, 0, 0,       7, 1, 0, 0, 0, 0);
        add("db_byp9_new", 0,  1,  1,    0,  0, 0,       0, 1, 0, 0,       9, 1, 0, 0, 0, 0);
        add("sat_ld127",   0,  0,  0,  127,  1, 1,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("sat_pos",     0,127,  1,    0,  0, 0,  262100, 1, 0, 0,  262143, 1, 1, 0, 1, -246059);
        add("sat_sticky",  0,  0,  0,    0,  0, 0,       5, 0, 0, 0,       5, 0, 1, 0, 0, 0);
        add("sat_clear",   0,  0,  0,    0,  0, 0,       0, 0, 1, 0,       0, 0, 0, 0, 0, 0);
        add("sat_neg",     0,-128, 1,    0,  0, 0, -262144, 1, 0, 0, -262144, 1, 1, 0, 1, 245888);
        add("sat_clr_set", 0,127,  1,    0,  0, 0,  262143, 1, 1, 0,  262143, 1, 1, 0, 1, -246016);
        add("sat_clr2",    0,  0,  0,    0,  0, 0,       0, 0, 1, 0,       0, 0, 0, 0, 0, 0);
        add("os_ldm3",     0,  0,  0,   -3,  1, 1,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("os_clr_mac",  1,  2,  1,    0,  0, 0,       0, 0, 1, 0,       0, 0, 0, 0, 0, 0);
        add("os_mac4",     1,  4,  1,    0,  0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("os_mac5",     1,  5,  1,    0,  0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("os_drain",    1,  0,  0,    0,  0, 0,      77, 0, 0, 1,     -33, 1, 0, 0, 0, 0);
        add("os_pass",     1,  0,  0,    0,  0, 0,      77, 1, 0, 0,      77, 1, 0, 0, 0, 0);
        add("os_coll",     1,  0,  0,    0,  0, 0,      55, 1, 0, 1,     -33, 1, 0, 1, 0, 0);
        add("os_coll_stk", 1,  0,  0,    0,  0, 0,       0, 0, 0, 0,       0, 0, 0, 1, 0, 0);
        add("os_clear",    1,  0,  0,    0,  0, 0,       0, 0, 1, 0,       0, 0, 0, 0, 0, 0);
        add("os_drain0",   1,  0,  0,    0,  0, 0,       0, 0, 0, 1,       0, 1, 0, 0, 0, 0);
        add("mt_mac3",     1,  3,  1,    0,  0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("mt_to_ws",    0,  0,  0,    0,  0, 0,      12, 0, 0, 1,      12, 0, 0, 0, 0, 0);
        add("mt_to_os",    1,  0,  0,    0,  0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add("mt_drain",    1,  0,  0,    0,  0, 0,       0, 0, 0, 1,       0, 1, 0, 0, 0, 0);

        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        check("rst.psum", int'(psum_out), 0);
        check("rst.pvalid", int'(psum_out_valid), 0);
        check("rst.dfcol", int'(df_col), 0);
        check("rst.wout", int'(w_out), 0);
        check("rst.flags", int'({sat_flag, coll_err, w_load_out, w_swap_out, df_valid}), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            mode = vecs[i].mode; din = vecs[i].din; din_valid = vecs[i].dv;
            w_in = vecs[i].w_in; w_load = vecs[i].wl; w_swap = vecs[i].ws;
            psum_in = vecs[i].pin; psum_in_valid = vecs[i].pv;
            acc_clear = vecs[i].clr; acc_drain = vecs[i].drn;
            sb.push_back(vecs[i]);
            tick();
            e = sb.pop_front();
            check({e.name, ".psum"}, int'(psum_out), int'(e.e_psum));
            check({e.name, ".pvalid"}, int'(psum_out_valid), int'(e.e_pv));
            check({e.name, ".sat"}, int'(sat_flag), int'(e.e_sat));
            check({e.name, ".coll"}, int'(coll_err), int'(e.e_coll));
            check({e.name, ".dfcol"}, int'(df_col), int'(e.din));
            check({e.name, ".dfvalid"}, int'(df_valid), int'(e.dv));
            if (e.chk_wrap)
                check({e.name, ".wrap"}, int'(wr_psum_out), int'(e.e_wrap));
        end

        // Reset in the middle of an OS accumulation with everything active.
        idle_inputs();
        mode = 1'b1; din = 8'sd3; din_valid = 1'b1; w_in = 8'sd5; w_load = 1'b1;
        psum_in = 19'sd9; psum_in_valid = 1'b1; acc_drain = 1'b1;
        tick();
        check("pre_rst.coll", int'(coll_err), 1);
        check("pre_rst.wout", int'(w_out), 5);
        rst = 1'b1;
        tick();
        check("mid_rst.psum", int'(psum_out), 0);
        check("mid_rst.dfcol", int'(df_col), 0);
        check("mid_rst.wout", int'(w_out), 0);
        check("mid_rst.bits", int'({psum_out_valid, df_valid, w_load_out, w_swap_out, sat_flag, coll_err}), 0);
        rst = 1'b0;
        idle_inputs();
        mode = 1'b1; acc_drain = 1'b1;
        tick();
        check("post_rst.drain", int'(psum_out), 0);
        check("post_rst.pvalid", int'(psum_out_valid), 1);

        // Weight daisy chain through two cascaded PEs.
        idle_inputs();
        w_load = 1'b1; w_in = 8'sd11;
        tick();
        check("chain.top11", int'(w_out), 11);
        check("chain.ldout", int'(w_load_out), 1);
        w_in = 8'sd22;
        tick();
        check("chain.top22", int'(w_out), 22);
        check("chain.bot11", int'(b_w_out), 11);
        idle_inputs();
        w_swap = 1'b1;
        tick();
        check("chain.top_swout", int'(w_swap_out), 1);
        check("chain.bot_swout0", int'(b_w_swap_out), 0);
        idle_inputs();
        din = 8'sd1; din_valid = 1'b1;
        tick();
        check("chain.top_swout0", int'(w_swap_out), 0);
        check("chain.bot_swout1", int'(b_w_swap_out), 1);
        check("chain.top_active", int'(psum_out), 22);

        idle_inputs();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
